// File: rtl/cond_unit_pkg.sv
// Shared controller definitions: condition codes, NZCV bit positions and
// FlagW field positions used by the conditional-execution stage.
package cond_unit_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FW_W    = 2;

    // Instr[31:28] condition codes
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    // Bit positions inside {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FlagW fields: [1] updates N,Z; [0] updates C,V
    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluator: Cond x {N,Z,C,V} -> CondEx.
// Ports: Cond (4b condition field), Flags (4b NZCV), CondEx (1b result).
module cond_check
    import cond_unit_pkg::*;
#(
    parameter bit NV_EXECUTES = 1'b0
) (
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Full 16-way decode so every Cond value yields a defined result
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ~(n ^ v);
            COND_LT: CondEx = n ^ v;
            COND_GT: CondEx = ~z & ~(n ^ v);
            COND_LE: CondEx = z | (n ^ v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = NV_EXECUTES;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates Cond and gates the
// decoder's PC/register/memory write requests with the condition decided
// in the decode cycle (CondExDelayed).
// Ports: clk, reset (async active-low); Cond, ALUFlags, FlagW, PCS, NextPC,
// RegW, MemW in; PCWrite, RegWrite, MemWrite, Flags, CondEx out.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter bit                 NV_EXECUTES = 1'b0,
    parameter logic [FLAGS_W-1:0] FLAGS_RESET = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [FW_W-1:0]    FlagW,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic [FLAGS_W-1:0] flags_q;
    logic               cond_ex_delayed;

    cond_check #(
        .NV_EXECUTES (NV_EXECUTES)
    ) u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (CondEx)
    );

    // Flag register (two independently enabled fields) and condition pipeline flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q         <= FLAGS_RESET;
            cond_ex_delayed <= 1'b0;
        end else begin
            cond_ex_delayed <= CondEx;
            if (FlagW[FW_NZ] & cond_ex_delayed) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FW_CV] & cond_ex_delayed) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Write gating; qualified by reset so enables drop the instant reset asserts
    assign PCWrite  = reset & ((PCS & cond_ex_delayed) | NextPC);
    assign RegWrite = reset & RegW & cond_ex_delayed;
    assign MemWrite = reset & MemW & cond_ex_delayed;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: a behavioural model predicts outputs for
// each driven cycle, pushes them to a queue, and they are popped and
// compared mid-cycle. A second instance covers NV_EXECUTES=1.
`timescale 1ns/1ps
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW;

    logic       PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
    logic       pcw_nv, rw_nv, mw_nv, cex_nv;
    logic [3:0] flags_nv;

    always #5 clk = ~clk;

    cond_unit #(.NV_EXECUTES(1'b0), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondEx(CondEx)
    );

    cond_unit #(.NV_EXECUTES(1'b1), .FLAGS_RESET(4'b0000)) dut_nv (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .PCWrite(pcw_nv), .RegWrite(rw_nv), .MemWrite(mw_nv),
        .Flags(flags_nv), .CondEx(cex_nv)
    );

    typedef struct {
        logic [3:0] flags;
        logic       condex;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic [3:0] flags_nv;
        logic       condex_nv;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Model state for both instances
    logic [3:0] m_flags, m_flags_nv;
    logic       m_cd, m_cd_nv;

    localparam logic [3:0] AL = 4'b1110;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: odd codes invert the even-code base condition; 1111 is special
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return nv;
        return base ^ c[0];
    endfunction

    function automatic exp_t predict(input logic [3:0] c, input logic p, input logic npc,
                                     input logic rw, input logic mw, input logic rst);
        exp_t e;
        e.flags     = m_flags;
        e.condex    = ref_cond(c, m_flags, 1'b0);
        e.pcw       = rst & ((p & m_cd) | npc);
        e.rw        = rst & rw & m_cd;
        e.mw        = rst & mw & m_cd;
        e.flags_nv  = m_flags_nv;
        e.condex_nv = ref_cond(c, m_flags_nv, 1'b1);
        return e;
    endfunction

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 4'd1, 4'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_flags"},    Flags,    e.flags);
        check({tag, "_condex"},   {3'b0, CondEx},   {3'b0, e.condex});
        check({tag, "_pcwrite"},  {3'b0, PCWrite},  {3'b0, e.pcw});
        check({tag, "_regwrite"}, {3'b0, RegWrite}, {3'b0, e.rw});
        check({tag, "_memwrite"}, {3'b0, MemWrite}, {3'b0, e.mw});
        check({tag, "_nv_flags"}, flags_nv, e.flags_nv);
        check({tag, "_nv_condex"}, {3'b0, cex_nv}, {3'b0, e.condex_nv});
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1
    task automatic cyc(input string tag, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic p, input logic npc,
                       input logic rw, input logic mw);
        logic cex, cex_n;
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = p; NextPC = npc; RegW = rw; MemW = mw;
        sb.push_back(predict(c, p, npc, rw, mw, reset));
        @(negedge clk);
        pop_and_check(tag);
        cex   = ref_cond(c, m_flags, 1'b0);
        cex_n = ref_cond(c, m_flags_nv, 1'b1);
        @(posedge clk);
        if (reset) begin
            if (fw[1] && m_cd)    m_flags[3:2]    = alu[3:2];
            if (fw[0] && m_cd)    m_flags[1:0]    = alu[1:0];
            if (fw[1] && m_cd_nv) m_flags_nv[3:2] = alu[3:2];
            if (fw[0] && m_cd_nv) m_flags_nv[1:0] = alu[1:0];
            m_cd    = cex;
            m_cd_nv = cex_n;
        end
        #1;
    endtask

    task automatic model_reset();
        m_flags = 4'b0000; m_flags_nv = 4'b0000; m_cd = 1'b0; m_cd_nv = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        Cond = AL; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b1; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;
        model_reset();

        // Held in reset: all enables forced low even with requests asserted
        @(posedge clk); #1;
        cyc("in_reset", AL, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);

        // Release: first cycle only NextPC can raise PCWrite
        reset = 1'b1;
        cyc("rel_c1", AL, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rel_c2", AL, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Set Z then EQ / NE
        cyc("setz",  AL,      4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("eq",    4'b0000, 4'h0,    2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("ne",    4'b0001, 4'h0,    2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("ne_wb", AL,      4'h0,    2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Independent NZ / CV field writes
        cyc("clr",   AL, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("nz_wr", AL, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("cv_wr", AL, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("fw_obs", AL, 4'h0,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=1,V=0: LT passes, GE fails and blocks its own flag write
        cyc("set_n", AL,      4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lt",    4'b1011, 4'h0,    2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("lt_wb", 4'b1011, 4'h0,    2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("ge",    4'b1010, 4'h0,    2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("ge_wb", 4'b1010, 4'b0111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("ge_obs", AL,     4'h0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full Cond x Flags sweep
        for (int f = 0; f < 16; f++) begin
            cyc("sw_pre", AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc("sw_set", AL, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                cyc("sweep", 4'(c), 4'(~f), 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-cycle with pending writes
        cyc("mr_pre1", AL, 4'b1101, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("mr_pre2", AL, 4'h0,    2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        sb.push_back(predict(AL, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        #1;
        pop_and_check("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        cyc("post_rst", AL, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("post_rst2", AL, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
